// File: rtl/muldiv_seq_unit_if.sv
// EX-stage <-> RV32M multiply/divide sequencer handshake bundle.
// master = EX stage driving the operation, slave = the sequencer.
interface muldiv_seq_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/muldiv_seq_unit.sv
// Multi-cycle RV32M multiply/divide sequencer (radix-2 shift-add / restoring divide).
// Define MULDIV_FAST_MUL_EN to replace the iterative multiplier with a single-cycle 33x33 one.
module muldiv_seq_unit #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  muldiv_seq_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LOAD = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [2:0]        op_r;
  logic              neg_r;
  logic [CW-1:0]     count_r;
  logic [2*XLEN-1:0] prod_r;
  logic [XLEN-1:0]   opb_r;
  logic [XLEN-1:0]   rem_r;
  logic [XLEN-1:0]   quo_r;
  logic [XLEN-1:0]   result_r;

  logic              accept_s;
  logic              a_signed_s;
  logic              b_signed_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic              neg_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic              special_s;
  logic [XLEN-1:0]   special_res_s;
  logic              fast_s;
  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN-1:0] mul_step_s;
  logic [XLEN:0]     div_shift_s;
  logic [XLEN:0]     div_trial_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   fix_res_s;
  logic              stall_s;
  logic              busy_s;
  logic              done_s;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    mag = neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Operand decode: signedness, magnitudes and the non-iterating special cases.
  always_comb begin
    accept_s   = (state_r == S_IDLE) & bus.start & ~bus.flush;
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (bus.funct3)
      3'b001:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      3'b010:  begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
      3'b100:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      3'b110:  begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      default: begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
    endcase
    a_neg_s = a_signed_s & bus.op_a[XLEN-1];
    b_neg_s = b_signed_s & bus.op_b[XLEN-1];
    a_mag_s = mag(bus.op_a, a_neg_s);
    b_mag_s = mag(bus.op_b, b_neg_s);
    // Remainder follows the dividend; everything else follows the operand sign product.
    if (bus.funct3[2] & bus.funct3[1]) begin
      neg_s = a_neg_s;
    end else begin
      neg_s = a_neg_s ^ b_neg_s;
    end
    div_zero_s = bus.funct3[2] & (bus.op_b == {XLEN{1'b0}});
    div_ovf_s  = bus.funct3[2] & ~bus.funct3[0] &
                 (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op_b);
    special_s  = div_zero_s | div_ovf_s;
    if (div_zero_s) begin
      special_res_s = bus.funct3[1] ? bus.op_a : {XLEN{1'b1}};
    end else if (div_ovf_s) begin
      special_res_s = bus.funct3[1] ? {XLEN{1'b0}} : bus.op_a;
    end else begin
      special_res_s = {XLEN{1'b0}};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a_s;
  logic signed [XLEN:0]     fast_b_s;
  logic signed [2*XLEN+1:0] fast_prod_s;
  logic [XLEN-1:0]          fast_res_s;

  // Single-cycle signed 33x33 product; zero-extension covers the unsigned operands.
  always_comb begin
    fast_s      = ~bus.funct3[2];
    fast_a_s    = {a_signed_s & bus.op_a[XLEN-1], bus.op_a};
    fast_b_s    = {b_signed_s & bus.op_b[XLEN-1], bus.op_b};
    fast_prod_s = $signed({{(XLEN+1){fast_a_s[XLEN]}}, fast_a_s}) *
                  $signed({{(XLEN+1){fast_b_s[XLEN]}}, fast_b_s});
    if (bus.funct3[1:0] == 2'b00) begin
      fast_res_s = fast_prod_s[XLEN-1:0];
    end else begin
      fast_res_s = fast_prod_s[2*XLEN-1:XLEN];
    end
  end
`else
  // Iterative multiplier only: no single-cycle shortcut.
  always_comb begin
    fast_s = 1'b0;
  end
`endif

  // One iteration of shift-add multiply and restoring divide, plus the final sign fix.
  always_comb begin
    mul_sum_s   = {1'b0, prod_r[2*XLEN-1:XLEN]} +
                  (prod_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
    mul_step_s  = {mul_sum_s, prod_r[XLEN-1:1]};
    div_shift_s = {rem_r, quo_r[XLEN-1]};
    div_trial_s = div_shift_s - {1'b0, opb_r};
    prod_fix_s  = neg_r ? (~prod_r + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_r;
    case (op_r)
      3'b000:                 fix_res_s = prod_fix_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res_s = mag(quo_r, neg_r);
      3'b110, 3'b111:         fix_res_s = mag(rem_r, neg_r);
      default:                fix_res_s = {XLEN{1'b0}};
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (special_s | fast_s) begin
            state_s = S_DONE;
          end else if (bus.funct3[2]) begin
            state_s = S_DIV;
          end else begin
            state_s = S_MUL;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (bus.flush) begin
          state_s = S_IDLE;
        end else if (count_r == CNT_ZERO) begin
          state_s = S_FIX;
        end else begin
          state_s = state_r;
        end
      end
      S_FIX:   state_s = bus.flush ? S_IDLE : S_DONE;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode; no stall request is raised while the unit is held in reset.
  always_comb begin
    stall_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      S_IDLE: stall_s = bus.start & ~bus.flush & rst;
      S_MUL, S_DIV, S_FIX: begin
        stall_s = 1'b1;
        busy_s  = 1'b1;
      end
      S_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        stall_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, iteration and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r     <= 3'b000;
      neg_r    <= 1'b0;
      count_r  <= CNT_ZERO;
      prod_r   <= {(2*XLEN){1'b0}};
      opb_r    <= {XLEN{1'b0}};
      rem_r    <= {XLEN{1'b0}};
      quo_r    <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r    <= bus.funct3;
            neg_r   <= neg_s;
            count_r <= CNT_LOAD;
            opb_r   <= b_mag_s;
            prod_r  <= {{XLEN{1'b0}}, a_mag_s};
            rem_r   <= {XLEN{1'b0}};
            quo_r   <= a_mag_s;
            if (special_s) begin
              result_r <= special_res_s;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (fast_s) begin
              result_r <= fast_res_s;
            end
`endif
          end
        end
        S_MUL: begin
          if (!bus.flush) begin
            prod_r  <= mul_step_s;
            count_r <= count_r - CNT_ONE;
          end
        end
        S_DIV: begin
          if (!bus.flush) begin
            count_r <= count_r - CNT_ONE;
            if (div_trial_s[XLEN]) begin
              rem_r <= div_shift_s[XLEN-1:0];
              quo_r <= {quo_r[XLEN-2:0], 1'b0};
            end else begin
              rem_r <= div_trial_s[XLEN-1:0];
              quo_r <= {quo_r[XLEN-2:0], 1'b1};
            end
          end
        end
        S_FIX: begin
          if (!bus.flush) begin
            result_r <= fix_res_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.stall  = stall_s;
  assign bus.busy   = busy_s;
  assign bus.done   = done_s;
  assign bus.result = result_r;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Self-checking bench for muldiv_seq_unit: vector table with a result scoreboard,
// latency/stall checks, and hand-written flush and reset-abort sequences.
module tb_muldiv_seq_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          spec;
    string       name;
  } vec_t;

  localparam int NV = 26;
  vec_t        vecs[NV];
  logic [31:0] sb_q[$];
  logic [31:0] last_res;

  muldiv_seq_unit_if #(.XLEN(32)) bus ();

  muldiv_seq_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] e, input bit s, input string n);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.exp = e; v.spec = s; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operation, hold start while stalled, then score result, latency and stall length.
  task automatic run_op(input vec_t v);
    int          edges;
    int          stalls;
    int          lat;
    logic [31:0] exp;
    lat = v.spec ? 1 : (v.f[2] ? 34 : MUL_LAT);
    bus.start  = 1'b1;
    bus.funct3 = v.f;
    bus.op_a   = v.a;
    bus.op_b   = v.b;
    sb_q.push_back(v.exp);
    #1;
    check({v.name, " stall_req"}, {31'd0, bus.stall}, 32'd1);
    @(posedge clk);
    edges  = 1;
    stalls = 0;
    #1;
    while (bus.done !== 1'b1 && edges < 60) begin
      if (bus.stall === 1'b1) stalls++;
      @(posedge clk);
      edges++;
      #1;
    end
    bus.start = 1'b0;
    exp = sb_q.pop_front();
    if (bus.done !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: no done after %0d edges, expected at edge %0d", v.name, edges, lat);
    end else begin
      check({v.name, " result"}, bus.result, exp);
      check({v.name, " done_edge"}, edges, lat);
      check({v.name, " stall_cycles"}, stalls, lat - 1);
      check({v.name, " stall_in_done"}, {31'd0, bus.stall}, 32'd0);
      last_res = exp;
    end
    @(posedge clk);
    #1;
    check({v.name, " done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    n_cmp = 0;
    n_err = 0;
    last_res = 32'd0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'd0;
    bus.op_b   = 32'd0;

    vecs[0]  = mk(3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "mul_7_m3");
    vecs[1]  = mk(3'b000, 32'h00000003, 32'h00000005, 32'h0000000F, 1'b0, "mul_3_5");
    vecs[2]  = mk(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, "mulh_min_min");
    vecs[3]  = mk(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, "mulh_m1_m1");
    vecs[4]  = mk(3'b001, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "mulh_7_m3");
    vecs[5]  = mk(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mulhsu_m1_max");
    vecs[6]  = mk(3'b010, 32'h00000002, 32'h80000000, 32'h00000001, 1'b0, "mulhsu_2_2p31");
    vecs[7]  = mk(3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, "mulhu_2p31");
    vecs[8]  = mk(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulhu_max_max");
    vecs[9]  = mk(3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, "div_m7_2");
    vecs[10] = mk(3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, "div_7_m2");
    vecs[11] = mk(3'b100, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'h00000004, 1'b0, "div_m8_m2");
    vecs[12] = mk(3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, "rem_m7_2");
    vecs[13] = mk(3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, "rem_7_m2");
    vecs[14] = mk(3'b110, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 1'b0, "rem_m8_m3");
    vecs[15] = mk(3'b101, 32'd100,      32'd7,        32'd14,       1'b0, "divu_100_7");
    vecs[16] = mk(3'b101, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, "divu_max_1");
    vecs[17] = mk(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, "divu_2p31_max");
    vecs[18] = mk(3'b111, 32'd100,      32'd7,        32'd2,        1'b0, "remu_100_7");
    vecs[19] = mk(3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, "remu_2p31_max");
    vecs[20] = mk(3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b1, "divu_by0");
    vecs[21] = mk(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, "div_by0");
    vecs[22] = mk(3'b110, 32'd100,      32'd0,        32'd100,      1'b1, "rem_by0");
    vecs[23] = mk(3'b111, 32'd5,        32'd0,        32'd5,        1'b1, "remu_by0");
    vecs[24] = mk(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, "rem_ovf");
    vecs[25] = mk(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_ovf");

    // Reset state
    #1;
    check("rst_busy",   {31'd0, bus.busy},  32'd0);
    check("rst_done",   {31'd0, bus.done},  32'd0);
    check("rst_stall",  {31'd0, bus.stall}, 32'd0);
    check("rst_result", bus.result,         32'd0);
    #21;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table, issued back-to-back
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i]);
    end

    // Flush while IDLE with start: nothing accepted
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    bus.funct3 = 3'b101;
    bus.op_a   = 32'd50;
    bus.op_b   = 32'd5;
    #1;
    check("idle_flush_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    check("idle_flush_busy", {31'd0, bus.busy}, 32'd0);
    bus.flush = 1'b0;

    // Flush DIV at iteration 10
    bus.funct3 = 3'b100;
    bus.op_a   = 32'd100;
    bus.op_b   = 32'd7;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    check("flush_pre_busy", {31'd0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check("flush_busy",   {31'd0, bus.busy}, 32'd0);
    check("flush_done",   {31'd0, bus.done}, 32'd0);
    check("flush_result", bus.result,        last_res);
    run_op(vecs[1]);

    // Reset in the middle of a MUL
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'd7;
    bus.op_b   = 32'hFFFFFFFD;
    @(posedge clk);
    #1;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy",   {31'd0, bus.busy},  32'd0);
    check("mid_rst_stall",  {31'd0, bus.stall}, 32'd0);
    check("mid_rst_done",   {31'd0, bus.done},  32'd0);
    check("mid_rst_result", bus.result,         32'd0);
    bus.start = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    run_op(mk(3'b101, 32'd9, 32'd3, 32'd3, 1'b0, "divu_9_3"));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide instructions in the EX stage of the 5-stage pipeline.
- Accepts an operation from EX and holds the pipeline with `stall` while it iterates.
- Presents a one-cycle `done` pulse with the 32-bit result, which EX forwards into the EX/MEM register in place of the ALU result.
- Handles the RISC-V divide-by-zero and signed-overflow special cases without iterating.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  EX holds an M-extension instruction; sampled only in IDLE
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  rs1 value (post-forwarding)
- op_b  in  XLEN  rs2 value (post-forwarding)
- flush  in  1  branch/jump flush of EX; aborts the current operation
- stall  out  1  freeze PC, IF/ID and ID/EX registers
- busy  out  1  FSM not in IDLE
- done  out  1  result valid, one-cycle pulse
- result  out  XLEN  product/quotient/remainder; held until next accepted start

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0, done=0, result=0; internal accumulators cleared.
  - Reset mid-operation discards the operation silently.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - On start=1 and flush=0: latch funct3 and operands.
  - Form absolute values per signedness: MULH signed×signed; MULHSU signed×unsigned; MULHU and DIVU/REMU unsigned; MUL uses low bits, so signedness is irrelevant.
  - Record result sign. Load count=XLEN-1.
  - Go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- Special cases, detected in IDLE, go straight to DONE with no iteration:
  - op_b=0: DIV/DIVU give all ones; REM/REMU give op_a.
  - DIV with op_a=0x80000000, op_b=0xFFFFFFFF: result 0x80000000. REM in the same case: result 0.
- MUL: radix-2 shift-add over a 2·XLEN product register, one bit per cycle, XLEN cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle, XLEN cycles, then FIX.
- FIX:
  - Apply sign correction. Quotient is negated if the operand signs differ. Remainder takes the dividend's sign.
  - Select the low half (MUL), high half (MULH*), quotient or remainder.
  - Register into result; go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE.
- Latency, counted in edges after the start-sampling edge:
  - Normal ops: done at edge XLEN+2.
  - Special cases: done at edge 1.
- stall = (state==IDLE & start & ~flush) | state∈{MUL,DIV,FIX}. Deasserted in DONE so EX advances with result that cycle.
- start while busy is ignored. EX is frozen by stall, so start stays high and is not re-sampled until IDLE.
  - Back-to-back: start high in the cycle after DONE begins a new operation.
- busy = state≠IDLE.
- flush (any state except DONE): return to IDLE at the next edge, no done pulse, result unchanged. flush in DONE has no effect on the pulse.
- All arithmetic is modulo 2^XLEN. Internal product width is 2·XLEN; divider remainder width is XLEN+1.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle signed 33×33 multiplier in IDLE and go directly to DONE; done at edge 1.
  - The MUL state is unused and unreachable.
  - Division is unchanged.
- Undefined: the iterative multiplier as described above; no DSP multiplier is inferred.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3), start 1 cycle → stall high 33 cycles; done at edge 34; result=0xFFFFFFEB. With MULDIV_FAST_MUL_EN: done at edge 1.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU same operands → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD. REM same → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. Each has done at edge 34.
- DIVU 100/0 → 0xFFFFFFFF; REM 100/0 → 100; DIV 0x80000000/0xFFFFFFFF → 0x80000000. Each has done at edge 1 and stall for 1 cycle.
- Start DIV, assert flush at iteration 10 → IDLE next edge, no done, result holds the previous value. Then an immediate MUL 3×5 → 15.
- Start MUL, pull rst low at iteration 5 → busy, stall, done and result all 0 immediately. After release, DIVU 9/3 → 3.
